// File: rtl/bus_rr_arbiter.sv
// Four-way round-robin bus arbiter feeding a 4:1 tri-state mux.
// Grants one owner at a time, with a programmable hold limit that ends each ownership.
module bus_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       gnt_valid
);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t     state, state_n;
    logic [1:0] owner, owner_n;
    logic [1:0] last, last_n;
    logic [7:0] hold_cnt, hold_n;
    logic [1:0] sel_n;
    logic [3:0] gnt_n;
    logic       gnt_valid_n;

    logic [1:0] base, idx, win;
    logic       found, any_req;

    // The search base is the owner while one exists, because an ending ownership
    // becomes "last" on this same edge. Otherwise the base is the recorded last owner.
    always_comb begin
        base  = (state == OWN) ? owner : last;
        win   = base;
        idx   = base;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        any_req = |req;
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n = OWN;
                    owner_n = win;
                    hold_n  = 8'd1;
                end
            end
            OWN: begin
                if (req[owner] && hold_cnt < HOLD_MAX) begin
                    hold_n = hold_cnt + 8'd1;
                end else begin
                    last_n = owner;
                    if (any_req) begin
                        owner_n = win;
                        hold_n  = 8'd1;
                    end else begin
                        state_n = IDLE;
                        hold_n  = 8'd0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                hold_n  = 8'd0;
            end
        endcase

        // sel keeps its value in IDLE, so the mux output stays stable between owners
        gnt_valid_n = (state_n == OWN);
        gnt_n       = gnt_valid_n ? (4'b0001 << owner_n) : 4'b0000;
        sel_n       = gnt_valid_n ? owner_n : sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 2'd0;
            last      <= 2'd3;
            hold_cnt  <= 8'd0;
            sel       <= 2'd0;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            last      <= last_n;
            hold_cnt  <= hold_n;
            sel       <= sel_n;
            gnt       <= gnt_n;
            gnt_valid <= gnt_valid_n;
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed and random checks of bus_rr_arbiter; two instances cover MAX_HOLD=4 and MAX_HOLD=3.
module tb_bus_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;

    logic [1:0] sel4, sel3;
    logic [3:0] gnt4, gnt3;
    logic       gv4, gv3;

    int total = 0;
    int npass = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    bus_rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .sel(sel4), .gnt(gnt4), .gnt_valid(gv4)
    );

    bus_rr_arbiter #(.MAX_HOLD(3)) dut3 (
        .clk(clk), .rst(rst), .req(req), .sel(sel3), .gnt(gnt3), .gnt_valid(gv3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] req_s;
        logic [3:0] prev_g;
        int         run;
        int         wait_c [4];
        int         maxw;

        // Reset with every requester pending
        rst = 1'b1; req = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_gnt", gnt4, 4'b0000);
            chk("rst_vld", gv4, 1'b0);
            chk("rst_sel", sel4, 2'd0);
        end
        rst = 1'b0;
        step();
        chk("first_gnt", gnt4, 4'b0001);
        chk("first_sel", sel4, 2'd0);
        chk("first_vld", gv4, 1'b1);

        // Full contention: four cycles for each owner, rotating upward
        for (int c = 1; c < 20; c++) begin
            step();
            chk("rr_gnt", gnt4, 4'b0001 << ((c / 4) % 4));
            chk("rr_sel", sel4, (c / 4) % 4);
        end

        // A lone requester is granted again at expiry with no gap
        rst = 1'b1; req = 4'b0100;
        step();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("solo_gnt", gnt4, 4'b0100);
            chk("solo_sel", sel4, 2'd2);
        end

        // Early release hands the bus over, then the arbiter goes idle with sel held
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0; req = 4'b0011;
        step();
        chk("er_gnt0", gnt4, 4'b0001);
        step();
        chk("er_gnt0b", gnt4, 4'b0001);
        req = 4'b0010;
        step();
        chk("er_gnt1", gnt4, 4'b0010);
        chk("er_sel1", sel4, 2'd1);
        req = 4'b0000;
        step();
        chk("er_idle_gnt", gnt4, 4'b0000);
        chk("er_idle_vld", gv4, 1'b0);
        chk("er_idle_sel", sel4, 2'd1);

        // Reset in the middle of an ownership restarts priority at requester 0
        req = 4'b1000;
        step();
        chk("mr_gnt3", gnt4, 4'b1000);
        chk("mr_sel3", sel4, 2'd3);
        rst = 1'b1;
        step();
        chk("mr_rst_gnt", gnt4, 4'b0000);
        chk("mr_rst_sel", sel4, 2'd0);
        rst = 1'b0; req = 4'b1001;
        step();
        chk("mr_gnt0", gnt4, 4'b0001);

        // Random traffic on the MAX_HOLD=3 instance; pending requests stay up until granted
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0;
        run = 0;
        prev_g = 4'b0000;
        for (int i = 0; i < 4; i++) wait_c[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            req_s = req;
            step();
            chk("rnd_onehot", ($countones(gnt3) <= 1), 1'b1);
            chk("rnd_vld", gv3, (gnt3 != 4'b0000));
            if (gnt3 != 4'b0000 && gnt3 == prev_g) run++;
            else run = (gnt3 != 4'b0000) ? 1 : 0;
            chk("rnd_hold", ((run > 3) && ((req_s & ~gnt3) != 4'b0000)), 1'b0);
            maxw = 0;
            for (int i = 0; i < 4; i++) begin
                if (req_s[i] && !gnt3[i]) wait_c[i]++;
                else wait_c[i] = 0;
                if (wait_c[i] > maxw) maxw = wait_c[i];
            end
            chk("rnd_latency", (maxw <= 9), 1'b1);
            prev_g = gnt3;
            for (int i = 0; i < 4; i++) begin
                if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
                else if (gnt3[i] && $urandom_range(0, 1) == 1) req[i] = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end

endmodule
